// File: rtl/regfile_sb_param.sv
// Parametrised register file: one write port, two registered read ports with hold,
// and a busy scoreboard for RAW hazard detection. Optional macro: REGFILE_BYPASS_EN.
module regfile_sb_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_busy,
    input  logic              rd2_en,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    output logic              rd2_busy,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              claim_err,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DATA_W-1:0] r_rd1_data;
    logic [DATA_W-1:0] r_rd2_data;
    logic              r_rd1_busy;
    logic              r_rd2_busy;
    logic              r_claim_err;
    logic [CNT_W-1:0]  r_busy_cnt;

    logic              w_wr_ok;
    logic              w_claim_ok;
    logic              w_claim_err;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_rd1_data;
    logic [DATA_W-1:0] w_rd2_data;
    logic              w_rd1_busy;
    logic              w_rd2_busy;

    // Register 0 ignores writes and claims when hardwired to zero.
    assign w_wr_ok    = wr_en    && !((ZERO_REG != 0) && (wr_addr == '0));
    assign w_claim_ok = claim_en && !((ZERO_REG != 0) && (claim_addr == '0));
    assign w_claim_err = w_claim_ok && r_busy[claim_addr]
                         && !(w_wr_ok && (wr_addr == claim_addr));

    // Next busy vector: write clears, claim sets, claim wins on collision.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[wr_addr] = 1'b0;
        end
        if (w_claim_ok) begin
            w_busy_nxt[claim_addr] = 1'b1;
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_busy_nxt[i]);
        end
    end

    always_comb begin
        w_rd1_data = r_mem[rd1_addr];
        w_rd1_busy = r_busy[rd1_addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_ok && (wr_addr == rd1_addr)) begin
            w_rd1_data = wr_data;
            w_rd1_busy = w_busy_nxt[rd1_addr];
        end
`endif
        if ((ZERO_REG != 0) && (rd1_addr == '0)) begin
            w_rd1_data = '0;
            w_rd1_busy = 1'b0;
        end
    end

    always_comb begin
        w_rd2_data = r_mem[rd2_addr];
        w_rd2_busy = r_busy[rd2_addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_ok && (wr_addr == rd2_addr)) begin
            w_rd2_data = wr_data;
            w_rd2_busy = w_busy_nxt[rd2_addr];
        end
`endif
        if ((ZERO_REG != 0) && (rd2_addr == '0)) begin
            w_rd2_data = '0;
            w_rd2_busy = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy      <= '0;
            r_rd1_data  <= '0;
            r_rd2_data  <= '0;
            r_rd1_busy  <= 1'b0;
            r_rd2_busy  <= 1'b0;
            r_claim_err <= 1'b0;
            r_busy_cnt  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_mem[wr_addr] <= wr_data;
            end
            if (rd1_en) begin
                r_rd1_data <= w_rd1_data;
                r_rd1_busy <= w_rd1_busy;
            end
            if (rd2_en) begin
                r_rd2_data <= w_rd2_data;
                r_rd2_busy <= w_rd2_busy;
            end
            r_busy      <= w_busy_nxt;
            r_claim_err <= w_claim_err;
            r_busy_cnt  <= w_cnt_nxt;
        end
    end

    assign rd1_data  = r_rd1_data;
    assign rd1_busy  = r_rd1_busy;
    assign rd2_data  = r_rd2_data;
    assign rd2_busy  = r_rd2_busy;
    assign claim_err = r_claim_err;
    assign busy_cnt  = r_busy_cnt;

endmodule

// File: tb/tb_regfile_sb_param.sv
// Directed bench for regfile_sb_param: default instance plus a ZERO_REG=1 instance on shared stimulus.
module tb_regfile_sb_param;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd1_en;
    logic [2:0]  rd1_addr;
    logic        rd2_en;
    logic [2:0]  rd2_addr;
    logic        claim_en;
    logic [2:0]  claim_addr;

    logic [31:0] d_rd1_data, d_rd2_data, z_rd1_data, z_rd2_data;
    logic        d_rd1_busy, d_rd2_busy, z_rd1_busy, z_rd2_busy;
    logic        d_claim_err, z_claim_err;
    logic [3:0]  d_busy_cnt, z_busy_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_sb_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0)) u_d (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(d_rd1_data), .rd1_busy(d_rd1_busy),
        .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(d_rd2_data), .rd2_busy(d_rd2_busy),
        .claim_en(claim_en), .claim_addr(claim_addr), .claim_err(d_claim_err),
        .busy_cnt(d_busy_cnt)
    );

    regfile_sb_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1)) u_z (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(z_rd1_data), .rd1_busy(z_rd1_busy),
        .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(z_rd2_data), .rd2_busy(z_rd2_busy),
        .claim_en(claim_en), .claim_addr(claim_addr), .claim_err(z_claim_err),
        .busy_cnt(z_busy_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd1_en = 1'b0; rd2_en = 1'b0; claim_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " d_rd1_data"}, d_rd1_data, 32'h0);
        chk({tag, " d_rd2_data"}, d_rd2_data, 32'h0);
        chk({tag, " d_rd1_busy"}, 32'(d_rd1_busy), 32'h0);
        chk({tag, " d_rd2_busy"}, 32'(d_rd2_busy), 32'h0);
        chk({tag, " d_claim_err"}, 32'(d_claim_err), 32'h0);
        chk({tag, " d_busy_cnt"}, 32'(d_busy_cnt), 32'h0);
        chk({tag, " z_rd1_data"}, z_rd1_data, 32'h0);
        chk({tag, " z_busy_cnt"}, 32'(z_busy_cnt), 32'h0);
    endtask

    initial begin
        idle();
        wr_addr = '0; wr_data = '0; rd1_addr = '0; rd2_addr = '0; claim_addr = '0;
        reset = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset_held");
        reset = 1'b1;
        tick();
        chk_all_zero("reset_released");

        // Every address reads zero and not busy after reset.
        for (int a = 0; a < 8; a++) begin
            rd1_en = 1'b1; rd1_addr = 3'(a);
            rd2_en = 1'b1; rd2_addr = 3'(7 - a);
            tick();
            chk("sweep rd1_data", d_rd1_data, 32'h0);
            chk("sweep rd2_data", d_rd2_data, 32'h0);
            chk("sweep rd1_busy", 32'(d_rd1_busy), 32'h0);
            chk("sweep rd2_busy", 32'(d_rd2_busy), 32'h0);
        end
        chk("sweep busy_cnt", 32'(d_busy_cnt), 32'h0);
        idle();

        // Write r5 then read on both ports.
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'd567;
        tick();
        idle();
        rd1_en = 1'b1; rd1_addr = 3'd5; rd2_en = 1'b1; rd2_addr = 3'd5;
        tick();
        chk("r5 rd1", d_rd1_data, 32'd567);
        chk("r5 rd2", d_rd2_data, 32'd567);
        chk("r5 rd1 zinst", z_rd1_data, 32'd567);
        idle();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'd99;
        tick();
        chk("r5 hold rd1", d_rd1_data, 32'd567);
        chk("r5 hold rd2", d_rd2_data, 32'd567);
        idle();
        rd1_en = 1'b1; rd1_addr = 3'd5;
        tick();
        chk("r5 reread", d_rd1_data, 32'd99);
        idle();

        // Register 0: hardwired in u_z, ordinary in u_d.
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hDEADBEEF;
        tick();
        idle();
        claim_en = 1'b1; claim_addr = 3'd0;
        tick();
        idle();
        rd1_en = 1'b1; rd1_addr = 3'd0;
        tick();
        chk("z r0 data", z_rd1_data, 32'h0);
        chk("z r0 busy", 32'(z_rd1_busy), 32'h0);
        chk("z r0 cnt", 32'(z_busy_cnt), 32'h0);
        chk("d r0 data", d_rd1_data, 32'hDEADBEEF);
        chk("d r0 busy", 32'(d_rd1_busy), 32'h1);
        chk("d r0 cnt", 32'(d_busy_cnt), 32'h1);
        idle();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h0;
        tick();
        chk("d r0 cleared cnt", 32'(d_busy_cnt), 32'h0);
        idle();

        // Scoreboard: claims, double claim error, write clears busy.
        claim_en = 1'b1; claim_addr = 3'd3;
        tick();
        chk("claim r3 cnt", 32'(d_busy_cnt), 32'h1);
        claim_addr = 3'd6;
        tick();
        chk("claim r6 cnt", 32'(d_busy_cnt), 32'h2);
        chk("claim r6 cnt z", 32'(z_busy_cnt), 32'h2);
        chk("claim r6 no err", 32'(d_claim_err), 32'h0);
        idle();
        rd1_en = 1'b1; rd1_addr = 3'd3; rd2_en = 1'b1; rd2_addr = 3'd3;
        tick();
        chk("r3 busy rd1", 32'(d_rd1_busy), 32'h1);
        chk("r3 busy rd2", 32'(d_rd2_busy), 32'h1);
        idle();
        claim_en = 1'b1; claim_addr = 3'd3;
        tick();
        chk("reclaim r3 err", 32'(d_claim_err), 32'h1);
        chk("reclaim r3 err z", 32'(z_claim_err), 32'h1);
        chk("reclaim r3 cnt", 32'(d_busy_cnt), 32'h2);
        idle();
        tick();
        chk("err pulse ends", 32'(d_claim_err), 32'h0);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'd12;
        tick();
        chk("wr r3 cnt", 32'(d_busy_cnt), 32'h1);
        idle();
        rd1_en = 1'b1; rd1_addr = 3'd3;
        tick();
        chk("r3 data", d_rd1_data, 32'd12);
        chk("r3 not busy", 32'(d_rd1_busy), 32'h0);
        idle();

        // Same-cycle claim and write: claim wins, no error.
        claim_en = 1'b1; claim_addr = 3'd2;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'd7;
        tick();
        chk("cw r2 cnt", 32'(d_busy_cnt), 32'h2);
        chk("cw r2 no err", 32'(d_claim_err), 32'h0);
        idle();
        rd1_en = 1'b1; rd1_addr = 3'd2;
        tick();
        chk("cw r2 data", d_rd1_data, 32'd7);
        chk("cw r2 busy", 32'(d_rd1_busy), 32'h1);
        idle();

        // Write and read r4 in the same cycle.
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'h11;
        tick();
        wr_data = 32'h55;
        rd1_en = 1'b1; rd1_addr = 3'd4;
        tick();
`ifdef REGFILE_BYPASS_EN
        chk("r4 same-cycle", d_rd1_data, 32'h55);
`else
        chk("r4 same-cycle", d_rd1_data, 32'h11);
`endif
        chk("r4 same-cycle busy", 32'(d_rd1_busy), 32'h0);
        wr_en = 1'b0;
        tick();
        chk("r4 next read", d_rd1_data, 32'h55);
        idle();

        // Make outputs nonzero, then reset asynchronously mid-cycle.
        claim_en = 1'b1; claim_addr = 3'd6;
        tick();
        chk("pre-reset err", 32'(d_claim_err), 32'h1);
        chk("pre-reset cnt", 32'(d_busy_cnt), 32'h2);
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        idle();
        tick();
        reset = 1'b1;
        rd1_en = 1'b1; rd1_addr = 3'd4; rd2_en = 1'b1; rd2_addr = 3'd6;
        tick();
        chk("post-reset r4", d_rd1_data, 32'h0);
        chk("post-reset r6 busy", 32'(d_rd2_busy), 32'h0);
        chk("post-reset cnt", 32'(d_busy_cnt), 32'h0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb_param.md
Name: regfile_sb_param

Overview:
Parametrised successor to the 8×32 register file, with configurable data width and depth. It has one write port, two read ports with 1-cycle registered latency, and per-register read-hold. A busy scoreboard tracks registers claimed by in-flight instructions so the control unit can detect RAW hazards. It sits between the decode/issue stage and the ALU operand latches of the CPU datapath.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 3, address width; depth = 2**ADDR_W
ZERO_REG, 0, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is ordinary

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write index
wr_data  in  DATA_W  write data
rd1_en  in  1  read port 1 update enable
rd1_addr  in  ADDR_W  read port 1 index
rd1_data  out  DATA_W  registered read data, port 1
rd1_busy  out  1  registered busy flag of the register read on port 1
rd2_en  in  1  read port 2 update enable
rd2_addr  in  ADDR_W  read port 2 index
rd2_data  out  DATA_W  registered read data, port 2
rd2_busy  out  1  registered busy flag, port 2
claim_en  in  1  mark claim_addr busy (issue of instruction writing it)
claim_addr  in  ADDR_W  register being claimed
claim_err  out  1  1-cycle pulse: claim to an already-busy register
busy_cnt  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset (reset=0, async): all registers = 0, all busy bits = 0. rd1_data, rd2_data, rd1_busy, rd2_busy, claim_err = 0; busy_cnt = 0. Reset asserted mid-operation discards pending writes and claims immediately.
- Write: on a clk edge with wr_en=1, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0. If ZERO_REG=1 and wr_addr=0, the write is ignored.
- Read: on a clk edge with rdN_en=1, rdN_data <= mem[rdN_addr] and rdN_busy <= busy[rdN_addr] (pre-edge values; see the optional feature). With rdN_en=0, rdN_data and rdN_busy hold. Latency is 1 cycle. If ZERO_REG=1, reading address 0 returns 0 with busy 0.
- Both read ports may address the same register in the same cycle; each returns the same value.
- Claim: on a clk edge with claim_en=1, busy[claim_addr] <= 1. A claim of register 0 with ZERO_REG=1 is ignored.
- Simultaneous claim and write to the same address: the register takes wr_data, and the claim wins, so the busy bit ends at 1 (back-to-back issue).
- Claim when busy[claim_addr] is already 1 and the same-cycle write does not clear it: claim_err = 1 for exactly the next cycle. The busy bit stays 1.
- busy_cnt equals the population count of the busy bits, updated registered, with the same latency as the busy bits. It changes by +1 (new claim), by −1 (write clears busy, no claim), or by 0 otherwise. Maximum value is 2**ADDR_W.
- Write to a non-busy register is legal and leaves busy at 0.
- Addresses are always in range by width; no wrap handling is needed.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding. If wr_en=1, rdN_en=1 and wr_addr=rdN_addr (and not a zero-register write), rdN_data <= wr_data. rdN_busy takes the post-edge busy value: 0 unless a same-cycle claim of that address.
- Undefined: the read returns the old mem contents and the pre-edge busy bit; the new value is visible on the next enabled read.

Test Plan:
1. Hold reset=0 for 3 cycles, then release -> all outputs 0; reading every address (DATA_W=32, ADDR_W=3) returns 0, busy 0, busy_cnt 0.
2. Write 567 to r5, then read r5 on port 1 and r5 on port 2 next cycle -> both rdN_data=567 one cycle after the read. Then drop rd1_en, write 99 to r5 -> rd1_data stays 567.
3. ZERO_REG=1: write 0xDEADBEEF to r0, claim r0, then read r0 -> rd1_data=0, rd1_busy=0, busy_cnt=0.
4. Claim r3, then claim r6 -> busy_cnt=2, reads of r3 show busy=1. Claim r3 again -> claim_err pulses 1 for one cycle. Write 12 to r3 -> busy_cnt=1, r3 reads 12 with busy 0.
5. Same cycle: claim r2 and write 7 to r2 -> r2=7, busy[r2]=1, busy_cnt +1, claim_err=0.
6. Write 0x55 to r4 and read r4 in the same cycle (old value 0x11): with REGFILE_BYPASS_EN, rd1_data=0x55; without it, rd1_data=0x11, and 0x55 on the next read. Assert reset mid-sequence -> all outputs 0 asynchronously, before the next clock edge.
